fft_out_serializer: RTL
=======================

// Module: fft_out_serializer
// PURPOSE
//  Downstream of top_fft_module. Captures one FFT frame of LANES-wide complex vectors
//  (valid_out burst, no backpressure) into a ping-pong frame buffer.
//  Drains the frame as one complex sample per cycle over a valid/ready stream to the
//  result writer / host link.
//  Two banks: one frame is captured while the previous frame is still draining.
// PARAMETERS
//  DATA   13  signed width of each re/im sample (matches FFT output)
//  LANES  16  samples per input vector
//  VECS   32  vectors per frame (frame = LANES*VECS = 512 samples)
//  IDX_W  $clog2(LANES*VECS)  width of the sample index (9)
// PORTS
//  clk        in   1           clock, all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  valid_in   in   1           input vector valid (driven by FFT valid_out)
//  din_re_t   in   DATA x LANES  signed real parts, lane j = sample vec*LANES+j
//  din_im_t   in   DATA x LANES  signed imaginary parts
//  dout_valid out  1           output sample valid
//  dout_ready in   1           downstream accepts sample when valid&ready
//  dout_re    out  DATA        signed real part of current sample
//  dout_im    out  DATA        signed imaginary part of current sample
//  dout_idx   out  IDX_W       frequency-bin index of current sample
//  dout_last  out  1           high with final sample of frame (dout_idx==LANES*VECS-1)
//  frame_drop out  1           1-cycle pulse: incoming frame discarded, no free bank
//  ovf_sticky out  1           set by frame_drop, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; both banks empty; wr_bank=0, rd_bank=0; wr_vec=0; rd_idx=0; FSM IDLE.
//  Write side:
//   - On valid_in, store the vector at address wr_vec in wr_bank and increment wr_vec.
//   - Gaps in valid_in hold wr_vec; the frame resumes when valid_in returns.
//   - When the vector at wr_vec==VECS-1 is stored: mark the bank full, set wr_vec=0,
//     toggle wr_bank.
//   - If valid_in is high with wr_vec==0 and wr_bank is full: discard the entire frame.
//     Ignore the next VECS valid vectors, pulse frame_drop once, set ovf_sticky.
//  Read FSM:
//   - IDLE: go to STREAM the cycle after rd_bank becomes full. dout_valid rises 1 cycle
//     after the full flag is set, so first output is 2 cycles after the last write.
//   - STREAM: dout_* registered from rd_bank[rd_idx]. Vector = rd_idx/LANES,
//     lane = rd_idx%LANES.
//   - dout_valid/dout_re/dout_im/dout_idx hold stable while dout_valid & !dout_ready.
//   - Each handshake advances rd_idx by 1. Back-to-back handshakes give 1 sample/cycle.
//   - On handshake with dout_last: clear rd_bank full, toggle rd_bank, rd_idx=0.
//     Go to STREAM if the other bank is already full (no bubble beyond 1 cycle),
//     else go to IDLE.
//  Bank-free timing: a bank freed at cycle N can be written from cycle N+1.
//   A write arriving at cycle N into that bank is a drop.
//  Simultaneous fill of one bank and drain-complete of the other: both take effect;
//   no drop.
//  Arithmetic: none. Data is copied bit-exact; no sign extension or rounding.
//  Mid-operation rst: all state is discarded, including partially written/drained frames.
//   Outputs are 0 in the cycle after rst is sampled high.
// CONFIGURATION
//  FFT_SER_BITREV_EN defined:
//   - Read address = bit-reverse(rd_idx over IDX_W bits); dout_idx = rd_idx.
//   - Bins leave in natural order from a bit-reversed FFT output.
//  FFT_SER_BITREV_EN undefined:
//   - Read address = rd_idx; samples leave in arrival order; dout_idx = rd_idx.
// TESTING
//  1. Reset, one 512-sample frame with re=k, im=-k (k = arrival index), ready=1:
//     512 consecutive samples. Without macro, sample n = (n,-n).
//     dout_last only at n=511.
//  2. Same as 1 with FFT_SER_BITREV_EN: dout_idx=1 carries re=256; dout_idx=3 carries re=384.
//  3. ready toggles 1/0 every cycle: sample values never change while valid&!ready.
//     Frame completes in 1023 cycles; no drop.
//  4. Three frames back-to-back (96 valid cycles), ready=1: frames 0 and 1 delivered.
//     Frame 2 arrives with both banks full: frame_drop pulses once, ovf_sticky=1.
//  5. valid_in gap of 5 cycles after vector 10: output identical to test 1.
//     First dout_valid 2 cycles after the 32nd vector.
//  6. rst asserted mid-drain at sample 200: next cycle all outputs 0.
//     A fresh frame then streams correctly from idx 0.

Source files
------------

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer: captures LANES-wide FFT vectors and drains one complex
// sample per cycle over valid/ready. Define FFT_SER_BITREV_EN to read in bit-reversed order.
module fft_out_serializer #(
    parameter int DATA  = 13,
    parameter int LANES = 16,
    parameter int VECS  = 32,
    parameter int IDX_W = $clog2(LANES*VECS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [LANES-1:0][DATA-1:0]   din_re_t,
    input  logic [LANES-1:0][DATA-1:0]   din_im_t,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DATA-1:0]       dout_re,
    output logic signed [DATA-1:0]       dout_im,
    output logic [IDX_W-1:0]             dout_idx,
    output logic                         dout_last,
    output logic                         frame_drop,
    output logic                         ovf_sticky
);
    localparam int LW = $clog2(LANES);
    localparam int VW = $clog2(VECS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES*VECS-1);
    localparam logic [VW-1:0]    LAST_VEC = VW'(VECS-1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [VW-1:0]     wr_vec_q, wr_vec_d, drop_cnt_q, drop_cnt_d;
    logic [1:0]        full_q, full_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
    logic [DATA-1:0]   dout_re_q, dout_re_d, dout_im_q, dout_im_d;
    logic [IDX_W-1:0]  dout_idx_q, dout_idx_d;
    logic              frame_drop_q, frame_drop_d, ovf_q, ovf_d;

    logic [LANES-1:0][DATA-1:0] bank_re_q [2*VECS];
    logic [LANES-1:0][DATA-1:0] bank_im_q [2*VECS];

    logic              mem_we, load, load_bank;
    logic [IDX_W-1:0]  load_idx, rd_addr;

    function automatic logic [IDX_W-1:0] map_addr(input logic [IDX_W-1:0] i);
`ifdef FFT_SER_BITREV_EN
        for (int b = 0; b < IDX_W; b++) map_addr[b] = i[IDX_W-1-b];
`else
        map_addr = i;
`endif
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_vec_d     = wr_vec_q;
        drop_cnt_d   = drop_cnt_q;
        full_d       = full_q;
        rd_idx_d     = rd_idx_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        dout_re_d    = dout_re_q;
        dout_im_d    = dout_im_q;
        dout_idx_d   = dout_idx_q;
        frame_drop_d = 1'b0;
        ovf_d        = ovf_q;
        mem_we       = 1'b0;
        load         = 1'b0;
        load_bank    = rd_bank_q;
        load_idx     = rd_idx_q;
        rd_addr      = '0;

        // A frame that starts while its bank is still full is swallowed whole.
        if (valid_in) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - VW'(1);
            end else if (wr_vec_q == '0 && full_q[wr_bank_q]) begin
                drop_cnt_d   = LAST_VEC;
                frame_drop_d = 1'b1;
                ovf_d        = 1'b1;
            end else begin
                mem_we = 1'b1;
                if (wr_vec_q == LAST_VEC) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_vec_d          = '0;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wr_vec_d = wr_vec_q + VW'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load     = 1'b1;
                    load_idx = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (dout_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        rd_idx_d          = '0;
                        if (full_q[~rd_bank_q]) begin
                            load      = 1'b1;
                            load_bank = ~rd_bank_q;
                            load_idx  = '0;
                        end else begin
                            state_d      = IDLE;
                            dout_valid_d = 1'b0;
                            dout_last_d  = 1'b0;
                            dout_re_d    = '0;
                            dout_im_d    = '0;
                            dout_idx_d   = '0;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                        load     = 1'b1;
                        load_idx = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            rd_addr      = map_addr(load_idx);
            dout_valid_d = 1'b1;
            dout_idx_d   = load_idx;
            dout_last_d  = (load_idx == LAST_IDX);
            dout_re_d    = bank_re_q[{load_bank, rd_addr[IDX_W-1:LW]}][rd_addr[LW-1:0]];
            dout_im_d    = bank_im_q[{load_bank, rd_addr[IDX_W-1:LW]}][rd_addr[LW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            bank_re_q[{wr_bank_q, wr_vec_q}] <= din_re_t;
            bank_im_q[{wr_bank_q, wr_vec_q}] <= din_im_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_vec_q     <= '0;
            drop_cnt_q   <= '0;
            full_q       <= '0;
            rd_idx_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_re_q    <= '0;
            dout_im_q    <= '0;
            dout_idx_q   <= '0;
            frame_drop_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_vec_q     <= wr_vec_d;
            drop_cnt_q   <= drop_cnt_d;
            full_q       <= full_d;
            rd_idx_q     <= rd_idx_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            dout_re_q    <= dout_re_d;
            dout_im_q    <= dout_im_d;
            dout_idx_q   <= dout_idx_d;
            frame_drop_q <= frame_drop_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign dout_idx   = dout_idx_q;
    assign dout_last  = dout_last_q;
    assign frame_drop = frame_drop_q;
    assign ovf_sticky = ovf_q;
endmodule
